multibyte_add_seq: RTL and testbench
====================================

# multibyte_add_seq

Sequential multi-byte adder controller that sits directly upstream of the 8-bit carry-lookahead adder `eb_adder_top` and consumes its result. It accepts a wide operand pair through a valid/ready handshake and feeds the 8-bit CLA one byte per cycle, least-significant byte first, chaining carry through a register. It collects the result bytes into a sum register and presents the final sum and carry-out through a valid/ready output handshake. One `eb_adder_top` instance is time-multiplexed across all bytes.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 1..16. `W = 8*NBYTES`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand pair and `cin` are valid.
- `in_ready` output 1: block can accept an operand pair.
- `a` input W: operand A.
- `b` input W: operand B.
- `cin` input 1: carry-in to byte 0.
- `out_valid` output 1: `sum` and `cout` are valid.
- `out_ready` input 1: downstream accepts the result.
- `sum` output W: registered result, equal to `(a + b + cin) mod 2^W`.
- `cout` output 1: carry out of the MSB.
- `ovf` output 1: signed overflow flag; present only with `MBA_OVF_EN`.

## Operation
- FSM states:
  - `IDLE`: `in_ready = 1`.
  - `ADD`: one byte is processed per cycle.
  - `DONE`: `out_valid = 1`.
- Leaving `IDLE`:
  - When `in_valid && in_ready` at a clock edge, latch `a`, `b` and `cin`.
  - Set byte index `idx` to 0, load the carry register with `cin`, clear `sum` to 0, and go to `ADD`.
- Each `ADD` cycle:
  - The CLA inputs are `A = a_q[8*idx +: 8]`, `B = b_q[8*idx +: 8]` and `Cin = carry_q`.
  - At the edge, write the CLA `Y` output into `sum[8*idx +: 8]` and load `carry_q` with the CLA `Cout`.
  - Increment `idx`.
  - When `idx == NBYTES-1`, also load `cout` with the CLA `Cout` and go to `DONE`.
- In `DONE`:
  - `sum` and `cout` are held stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`, go to `IDLE`.
- `in_ready` is asserted only in `IDLE`. `in_valid` in any other state is ignored, and the operands are not latched.
- Arithmetic is unsigned modulo 2^W. Carry propagates across all byte boundaries, including a full ripple of a 1 from byte 0 to the MSB.
- `idx` width is `$clog2(NBYTES)`, minimum 1. `idx` never wraps past `NBYTES-1`.
- Reset (asynchronous, any state, including mid-`ADD`):
  - state = `IDLE`, `idx` = 0, `carry_q` = 0.
  - `sum` = 0, `cout` = 0, `out_valid` = 0.
  - `in_ready` = 1 (from state decode); `ovf` = 0.
  - Any partial result is discarded.
  - Operands are accepted only on clock edges with `rst_n` high.

## Timing
- Accept at edge k. `ADD` occupies edges k+1 .. k+NBYTES. `out_valid` rises after edge k+NBYTES, giving a latency of NBYTES cycles from the accept edge.
- The earliest next accept is the edge after the `DONE` handshake edge. Peak throughput is therefore one operation per NBYTES+2 cycles.
- `NBYTES = 1`: a single `ADD` cycle; `out_valid` is high 1 cycle after accept.
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from `in_valid` or `out_ready` to either signal.
- `sum`, `cout` and `ovf` change only on the edge that writes them or on reset, never while `out_valid` is high.

## Configuration
- `MBA_OVF_EN` defined:
  - The `ovf` port exists.
  - `ovf` is registered on the final `ADD` edge as `(a_q[W-1] ^ b_q[W-1] ^ Y[7]) ^ Cout`, i.e. carry into the MSB XOR carry out of it.
  - `ovf` is held through `DONE` and reset to 0.
- `MBA_OVF_EN` undefined: the `ovf` port and its register are absent. All other behaviour is identical.

## Test plan
All scenarios use NBYTES=4.
- Single-byte carry: `a=0x000000FF`, `b=0x00000001`, `cin=0` -> `sum=0x00000100`, `cout=0`; `out_valid` rises exactly 4 cycles after the accept edge.
- Full ripple: `a=0xFFFFFFFF`, `b=0x00000000`, `cin=1` -> `sum=0x00000000`, `cout=1`.
- Signed overflow (`MBA_OVF_EN` defined): `a=0x7FFFFFFF`, `b=0x00000001`, `cin=0` -> `sum=0x80000000`, `cout=0`, `ovf=1`. A second case, `0x12345678 + 0x11111111`, gives `sum=0x23456789`, `cout=0`, `ovf=0`.
- Backpressure: hold `out_ready=0` for 5 cycles in `DONE` while driving `in_valid=1` with new operands. `sum` and `cout` stay stable, `in_ready` stays 0, and the new operands are not latched. On `out_ready=1`, the next cycle shows `in_ready=1`.
- Reset mid-operation: assert `rst_n=0` during the third `ADD` cycle -> immediately `out_valid=0`, `sum=0`, `cout=0`, `in_ready=1`. After release, `100 + 50` with `cin=0` gives `sum=150`, `cout=0`.
- Back-to-back: two operations issued as soon as `in_ready` allows; `15+15+1=31`, then `0xFFFFFFFE+1+1` giving `sum=0`, `cout=1`. Both results are correct, with no carry leaking between operations.

Source files
------------

// File: rtl/multibyte_add_seq_if.sv
// rtl/multibyte_add_seq_if.sv - operand/result handshake bundle for multibyte_add_seq
//   in_valid/in_ready/a/b/cin : operand pair channel (master drives, slave accepts)
//   out_valid/out_ready/sum/cout : result channel (slave drives, master accepts)
//   ovf : signed overflow, present only when MBA_OVF_EN is defined
interface multibyte_add_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef MBA_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef MBA_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef MBA_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/multibyte_add_seq.sv
// rtl/multibyte_add_seq.sv - byte-serial wide adder driving one 8-bit CLA
//   eb_adder_top      : 8-bit carry-lookahead adder (A, B, Cin -> Y, Cout)
//   multibyte_add_seq : clk, rst_n (async active-low), bus (multibyte_add_seq_if.slave)
//   Optional macro MBA_OVF_EN adds the registered signed-overflow output bus.ovf.
module eb_adder_top (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Y,
  output logic       Cout
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  // Each carry is the OR of the generate terms below it, each gated by the
  // propagate chain up to this bit, plus Cin gated by the whole chain.
  function automatic logic [8:0] lookahead(input logic [7:0] g, input logic [7:0] p,
                                           input logic ci);
    logic [8:0] c;
    logic       term;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int k = 0; k <= i; k++) begin
        term = g[k];
        for (int j = k + 1; j <= i; j++) term = term & p[j];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  assign w_g  = A & B;
  assign w_p  = A ^ B;
  assign w_c  = lookahead(w_g, w_p, Cin);
  assign Y    = w_p ^ w_c[7:0];
  assign Cout = w_c[8];

endmodule

module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multibyte_add_seq_if.slave bus
);

  localparam int            W    = 8 * NBYTES;
  localparam int            IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_cout;
  logic          r_in_ready;
  logic          r_out_valid;
`ifdef MBA_OVF_EN
  logic          r_ovf;
`endif

  logic [7:0]    w_byte_a;
  logic [7:0]    w_byte_b;
  logic [7:0]    w_y;
  logic          w_cout;

  assign w_byte_a = r_a[8*r_idx +: 8];
  assign w_byte_b = r_b[8*r_idx +: 8];

  eb_adder_top u_cla (
    .A    (w_byte_a),
    .B    (w_byte_b),
    .Cin  (r_carry),
    .Y    (w_y),
    .Cout (w_cout)
  );

  // Handshake flags are registered copies of the state decode, so neither
  // in_ready nor out_valid has a combinational path from the bus inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef MBA_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_carry    <= bus.cin;
            r_idx      <= '0;
            r_sum      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ADD;
          end
        end
        ADD: begin
          r_sum[8*r_idx +: 8] <= w_y;
          r_carry             <= w_cout;
          if (r_idx == LAST) begin
            r_cout      <= w_cout;
`ifdef MBA_OVF_EN
            // Operand MSBs XOR result MSB recovers the carry into bit W-1.
            r_ovf       <= (r_a[W-1] ^ r_b[W-1] ^ w_y[7]) ^ w_cout;
`endif
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
`ifdef MBA_OVF_EN
  assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb/tb_multibyte_add_seq.sv - scoreboard bench for multibyte_add_seq with NBYTES=4
module tb_multibyte_add_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   acc_cyc;
  int   last_rise;
  logic prev_ov;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    string       nm;
  } exp_t;

  exp_t q[$];

  multibyte_add_seq_if #(.NBYTES(4)) bus ();

  multibyte_add_seq #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_ov) last_rise = cyc;
      prev_ov = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got sum 0x%0h expected no output", bus.sum);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.nm, "_sum"}, 64'(bus.sum), 64'(e.s));
          chk({e.nm, "_cout"}, 64'(bus.cout), 64'(e.c));
`ifdef MBA_OVF_EN
          chk({e.nm, "_ovf"}, 64'(bus.ovf), 64'(e.o));
`endif
        end
      end
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input bit push, input logic [31:0] es, input logic ec,
                       input logic eo, input string nm);
    int n;
    logic ok;
    if (push) q.push_back('{s: es, c: ec, o: eo, nm: nm});
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    bus.in_valid = 1'b0;
    acc_cyc      = cyc;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_accept: got in_ready 0 expected 1 within 100 cycles", nm);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({nm, "_drain"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int a1;
    int n;
    total         = 0;
    bad           = 0;
    cyc           = 0;
    last_rise     = 0;
    prev_ov       = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    #23;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
`ifdef MBA_OVF_EN
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'h000000FF, 32'h00000001, 1'b0, 1, 32'h00000100, 1'b0, 1'b0, "byte_carry");
    drain("byte_carry");
    chk("byte_carry_latency", 64'(last_rise - acc_cyc), 64'd4);

    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 32'h00000000, 1'b1, 1'b0, "full_ripple");
    drain("full_ripple");

    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1, 32'h80000000, 1'b0, 1'b1, "ovf_pos");
    drain("ovf_pos");
    issue(32'h12345678, 32'h11111111, 1'b0, 1, 32'h23456789, 1'b0, 1'b0, "no_ovf");
    drain("no_ovf");

    // Backpressure with competing operands on the input side.
    bus.out_ready = 1'b0;
    issue(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1, 32'hFFFFFFFF, 1'b0, 1'b0, "bp");
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_rise", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    bus.a        = 32'h11111111;
    bus.b        = 32'h22222222;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_sum_hold", 64'(bus.sum), 64'hFFFFFFFF);
      chk("bp_cout_hold", 64'(bus.cout), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    issue(32'h11111111, 32'h22222222, 1'b0, 1, 32'h33333333, 1'b0, 1'b0, "post_bp");
    drain("post_bp");

    // Reset during the third ADD cycle discards the partial result.
    issue(32'h01020304, 32'h01010101, 1'b0, 0, 32'h0, 1'b0, 1'b0, "rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_mid_partial", 64'(bus.sum), 64'h00000405);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_sum", 64'(bus.sum), 64'd0);
    chk("rst_mid_cout", 64'(bus.cout), 64'd0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'd100, 32'd50, 1'b0, 1, 32'd150, 1'b0, 1'b0, "after_rst");
    drain("after_rst");

    // Back-to-back issue: second accept lands NBYTES+2 cycles after the first.
    issue(32'd15, 32'd15, 1'b1, 1, 32'd31, 1'b0, 1'b0, "b2b_first");
    a1 = acc_cyc;
    issue(32'hFFFFFFFE, 32'h00000001, 1'b1, 1, 32'h00000000, 1'b1, 1'b0, "b2b_second");
    chk("b2b_spacing", 64'(acc_cyc - a1), 64'd6);
    drain("b2b");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
